// File: rtl/wb_motor_pwm_pkg.sv
// Shared constants and types for the Wishbone wheel-motor PWM driver.
package wb_motor_pwm_pkg;

   // Counter, shadow and deadtime width
   localparam int unsigned CNT_W = 16;

   // Default register byte offsets
   localparam int unsigned CTRL_OFFS   = 0;
   localparam int unsigned PERIOD_OFFS = 4;
   localparam int unsigned DUTY_OFFS   = 8;
   localparam int unsigned STATUS_OFFS = 12;

   // CTRL bit positions
   localparam int unsigned CTRL_ENABLE = 0;
   localparam int unsigned CTRL_DIR    = 1;
   localparam int unsigned CTRL_BRAKE  = 2;
   localparam int unsigned CTRL_IRQ_EN = 3;
   localparam int unsigned CTRL_W      = 4;

   // STATUS bit positions
   localparam int unsigned STATUS_DONE    = 0;
   localparam int unsigned STATUS_DEAD    = 1;
   localparam int unsigned STATUS_CNT_LSB = 16;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDead = 2'd2
   } state_e;

endpackage

// File: rtl/wb_motor_pwm_core.sv
// PWM engine: period counter, shadow registers, IDLE/RUN/DEAD FSM,
// direction deadtime and pwm/dir/brake/irq generation.
module wb_motor_pwm_core
   import wb_motor_pwm_pkg::*;
#(
   parameter int unsigned DeadTime = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             dir_cfg,
   input  logic             brake_cfg,
   input  logic             irq_en,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] duty,
   output logic             pwm,
   output logic             dir,
   output logic             brake,
   output logic             irq,
   output logic             wrap,
   output logic             dead,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] DtLoad = CNT_W'(DeadTime - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_s_q, period_s_d;
   logic [CNT_W-1:0] duty_s_q, duty_s_d;
   logic [CNT_W-1:0] dt_q, dt_d;
   logic             pwm_q, pwm_d;
   logic             dir_q, dir_d;
   logic             brake_q;
   logic             irq_q, irq_d;
   logic             wrap_hit;
   logic [CNT_W-1:0] cnt_adv;

   // Next-state, counter advance and output decisions
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      period_s_d = period_s_q;
      duty_s_d   = duty_s_q;
      dt_d       = dt_q;
      dir_d      = dir_q;
      pwm_d      = 1'b0;
      irq_d      = 1'b0;
      wrap       = 1'b0;

      // Period 0 parks the counter and never wraps
      wrap_hit = (period_s_q != '0) && (cnt_q == period_s_q - 1'b1);
      cnt_adv  = (period_s_q == '0 || wrap_hit) ? '0 : cnt_q + 1'b1;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            dir_d = dir_cfg;
            if (enable) begin
               state_d    = StRun;
               period_s_d = period;
               duty_s_d   = duty;
            end
         end
         StRun, StDead: begin
            if (!enable) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_adv;
               if (wrap_hit) begin
                  period_s_d = period;
                  duty_s_d   = duty;
                  wrap       = 1'b1;
                  irq_d      = irq_en;
               end
               if (state_q == StRun) begin
                  if (dir_cfg != dir_q) begin
                     state_d = StDead;
                     dt_d    = DtLoad;
                  end else begin
                     pwm_d = (period_s_q != '0) && (cnt_q < duty_s_q);
                  end
               end else if (dt_q == '0) begin
                  // Takes whatever dir is requested now; a toggle-back is a no-op
                  dir_d   = dir_cfg;
                  state_d = StRun;
               end else begin
                  dt_d = dt_q - 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Brake overrides the bridge enable without touching FSM or counters
      if (brake_cfg) pwm_d = 1'b0;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         period_s_q <= '0;
         duty_s_q   <= '0;
         dt_q       <= '0;
         pwm_q      <= 1'b0;
         dir_q      <= 1'b0;
         brake_q    <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         period_s_q <= period_s_d;
         duty_s_q   <= duty_s_d;
         dt_q       <= dt_d;
         pwm_q      <= pwm_d;
         dir_q      <= dir_d;
         brake_q    <= brake_cfg;
         irq_q      <= irq_d;
      end
   end

   assign pwm   = pwm_q;
   assign dir   = dir_q;
   assign brake = brake_q;
   assign irq   = irq_q;
   assign dead  = (state_q == StDead);
   assign cnt   = cnt_q;

endmodule

// File: rtl/wb_motor_pwm.sv
// Wishbone slave for the wheel-motor PWM driver: bus handshake, register
// file, STATUS sticky flag and read mux around the PWM engine.
module wb_motor_pwm
   import wb_motor_pwm_pkg::*;
#(
   parameter int unsigned C_WB_DWIDTH    = 32,
   parameter int unsigned C_WB_CTRLREG   = CTRL_OFFS,
   parameter int unsigned C_WB_PERIODREG = PERIOD_OFFS,
   parameter int unsigned C_WB_DUTYREG   = DUTY_OFFS,
   parameter int unsigned C_WB_STATUSREG = STATUS_OFFS,
   parameter int unsigned C_DEADTIME     = 16
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   wb_we_i,
   input  logic                   wb_cyc_i,
   input  logic                   wb_stb_i,
   output logic                   wb_ack_o,
   input  logic [C_WB_DWIDTH-1:0] wb_data_i,
   output logic [C_WB_DWIDTH-1:0] wb_data_o,
   input  logic [C_WB_DWIDTH-1:0] wb_addr_i,
   output logic                   pwm_o,
   output logic                   dir_o,
   output logic                   brake_o,
   output logic                   irq_o
);

   logic                   ack_q;
   logic [C_WB_DWIDTH-1:0] rdata_q, rdata_d;
   logic [CTRL_W-1:0]      ctrl_q;
   logic [CNT_W-1:0]       period_q, duty_q;
   logic                   done_q, done_d;
   logic                   access, wr, rd;
   logic                   sel_ctrl, sel_period, sel_duty, sel_status;
   logic                   wrap, dead;
   logic [CNT_W-1:0]       cnt;
   logic                   unused_wdata;

   assign unused_wdata = ^wb_data_i[C_WB_DWIDTH-1:CNT_W];

   // Access decode, read mux and sticky period_done update
   always_comb begin
      // The ~ack term splits a held strobe into alternate-cycle accesses
      access     = wb_stb_i & wb_cyc_i & ~ack_q;
      wr         = access & wb_we_i;
      rd         = access & ~wb_we_i;
      sel_ctrl   = (wb_addr_i == C_WB_DWIDTH'(C_WB_CTRLREG));
      sel_period = (wb_addr_i == C_WB_DWIDTH'(C_WB_PERIODREG));
      sel_duty   = (wb_addr_i == C_WB_DWIDTH'(C_WB_DUTYREG));
      sel_status = (wb_addr_i == C_WB_DWIDTH'(C_WB_STATUSREG));

      rdata_d = '0;
      if (sel_ctrl) begin
         rdata_d[CTRL_W-1:0] = ctrl_q;
      end else if (sel_period) begin
         rdata_d[CNT_W-1:0] = period_q;
      end else if (sel_duty) begin
         rdata_d[CNT_W-1:0] = duty_q;
      end else if (sel_status) begin
         rdata_d[STATUS_DONE]                 = done_q;
         rdata_d[STATUS_DEAD]                 = dead;
         rdata_d[STATUS_CNT_LSB +: CNT_W]     = cnt;
      end

      // A wrap in the same cycle as a write-1-to-clear keeps the flag set
      done_d = done_q;
      if (wrap) begin
         done_d = 1'b1;
      end else if (wr && sel_status && wb_data_i[STATUS_DONE]) begin
         done_d = 1'b0;
      end
   end

   // Bus and register file state
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q    <= 1'b0;
         rdata_q  <= '0;
         ctrl_q   <= '0;
         period_q <= '0;
         duty_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         ack_q  <= access;
         done_q <= done_d;
         if (wr && sel_ctrl)   ctrl_q   <= wb_data_i[CTRL_W-1:0];
         if (wr && sel_period) period_q <= wb_data_i[CNT_W-1:0];
         if (wr && sel_duty)   duty_q   <= wb_data_i[CNT_W-1:0];
         if (rd)               rdata_q  <= rdata_d;
      end
   end

   assign wb_ack_o  = ack_q;
   assign wb_data_o = rdata_q;

   wb_motor_pwm_core #(
      .DeadTime (C_DEADTIME)
   ) u_core (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .enable    (ctrl_q[CTRL_ENABLE]),
      .dir_cfg   (ctrl_q[CTRL_DIR]),
      .brake_cfg (ctrl_q[CTRL_BRAKE]),
      .irq_en    (ctrl_q[CTRL_IRQ_EN]),
      .period    (period_q),
      .duty      (duty_q),
      .pwm       (pwm_o),
      .dir       (dir_o),
      .brake     (brake_o),
      .irq       (irq_o),
      .wrap      (wrap),
      .dead      (dead),
      .cnt       (cnt)
   );

endmodule

// File: tb/tb_wb_motor_pwm.sv
// Directed bench for wb_motor_pwm: bus reads and per-cycle output
// expectations go through a queue and are compared as results appear.
module tb_wb_motor_pwm;

   logic        clk = 1'b0;
   logic        rst, we, cyc, stb, ack;
   logic [31:0] wdata, rdata, addr;
   logic        pwm, dir, brake, irq;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_n   = 0;
   int base    = 0;

   logic [31:0] rd_exp_q[$];
   logic [31:0] rd_mask_q[$];
   logic [4:0]  out_exp_q[$];

   localparam logic [31:0] A_CTRL   = 32'd0;
   localparam logic [31:0] A_PERIOD = 32'd4;
   localparam logic [31:0] A_DUTY   = 32'd8;
   localparam logic [31:0] A_STATUS = 32'd12;

   always #5 clk = ~clk;

   wb_motor_pwm dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wb_we_i   (we),
      .wb_cyc_i  (cyc),
      .wb_stb_i  (stb),
      .wb_ack_o  (ack),
      .wb_data_i (wdata),
      .wb_data_o (rdata),
      .wb_addr_i (addr),
      .pwm_o     (pwm),
      .dir_o     (dir),
      .brake_o   (brake),
      .irq_o     (irq)
   );

   // {pwm, irq, dir, brake, ack}
   function automatic logic [4:0] mk(input bit p, input bit i, input bit d, input bit b);
      return {p, i, d, b, 1'b0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   // Queue the expected outputs, advance n cycles, then compare
   task automatic cyc_chk(input string tag, input int n, input logic [4:0] exp);
      logic [4:0] got, want;
      out_exp_q.push_back(exp);
      for (int i = 0; i < n; i++) step();
      got  = {pwm, irq, dir, brake, ack};
      want = out_exp_q.pop_front();
      n_tests++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s j=%0d {pwm,irq,dir,brake,ack}: observed %b expected %b",
                tag, cyc_n - base, got, want);
      end
   endtask

   // One Wishbone access; reads compare (rdata & mask) against exp
   task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input logic [31:0] mask, input string tag);
      logic [31:0] e, m;
      cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
      if (!w) begin
         rd_exp_q.push_back(exp);
         rd_mask_q.push_back(mask);
      end
      step();
      n_tests++;
      assert (ack === 1'b1) else begin
         n_fail++;
         $error("FAIL %s ack_one_cycle: observed %b expected 1", tag, ack);
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (!w) begin
         e = rd_exp_q.pop_front();
         m = rd_mask_q.pop_front();
         n_tests++;
         assert ((rdata & m) === e) else begin
            n_fail++;
            $error("FAIL %s rdata: observed %h expected %h (mask %h)", tag, rdata & m, e, m);
         end
      end
      step();
      n_tests++;
      assert (ack === 1'b0) else begin
         n_fail++;
         $error("FAIL %s ack_pulse_width: observed %b expected 0", tag, ack);
      end
   endtask

   task automatic wait_irq(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         if (irq === 1'b1) seen = 1'b1;
      end
      n_tests++;
      assert (seen) else begin
         n_fail++;
         $error("FAIL %s irq_sync: observed no pulse in 40 cycles expected a pulse", tag);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish expected finish before 500us");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      step();
      step();
      cyc_chk("reset_outputs", 0, 5'b0);
      rst = 1'b0;
      bus(1'b0, A_CTRL,   0, 32'h0, 32'hFFFF_FFFF, "rst_ctrl");
      bus(1'b0, A_PERIOD, 0, 32'h0, 32'hFFFF_FFFF, "rst_period");
      bus(1'b0, A_DUTY,   0, 32'h0, 32'hFFFF_FFFF, "rst_duty");
      bus(1'b0, A_STATUS, 0, 32'h0, 32'hFFFF_FFFF, "rst_status");
      bus(1'b0, 32'h100,  0, 32'h0, 32'hFFFF_FFFF, "unmapped_read");

      // Basic 3/10 PWM with irq
      bus(1'b1, A_PERIOD, 32'hFFFF_000A, 0, 0, "wr_period");
      bus(1'b1, A_DUTY,   32'd3,         0, 0, "wr_duty");
      bus(1'b0, A_PERIOD, 0, 32'd10, 32'hFFFF_FFFF, "period_upper_zero");
      bus(1'b1, A_CTRL,   32'h9,         0, 0, "wr_ctrl_en");
      base = cyc_n - 1;
      cyc_chk("b_first", 0, mk(0, 0, 0, 0));
      for (int k = 2; k <= 30; k++)
         cyc_chk("b_pwm", 1, mk(((k - 2) % 10) < 3, ((k - 2) % 10) == 9, 0, 0));
      bus(1'b0, A_STATUS, 0, 32'h1, 32'h3, "status_done_set");
      bus(1'b1, A_STATUS, 32'h1, 0, 0, "status_clear");
      bus(1'b0, A_STATUS, 0, 32'h0, 32'h1, "status_done_clr");

      // Duty change mid-period takes effect on the next period
      wait_irq("c_sync");
      base = cyc_n;
      cyc_chk("c_j1", 1, mk(1, 0, 0, 0));
      bus(1'b1, A_DUTY, 32'd8, 0, 0, "wr_duty8");
      for (int j = 4; j <= 20; j++)
         cyc_chk("c_duty8", 1, mk(((j - 1) % 10) < ((j <= 10) ? 3 : 8), (j % 10) == 0, 0, 0));
      bus(1'b1, A_DUTY, 32'd12, 0, 0, "wr_duty12");
      wait_irq("c_sync12");
      base = cyc_n;
      for (int j = 1; j <= 20; j++)
         cyc_chk("c_full", 1, mk(1, (j % 10) == 0, 0, 0));
      bus(1'b1, A_PERIOD, 32'd0, 0, 0, "wr_period0");
      wait_irq("c_sync0");
      base = cyc_n;
      for (int j = 1; j <= 30; j++)
         cyc_chk("c_period0", 1, mk(0, 0, 0, 0));
      bus(1'b0, A_STATUS, 0, 32'h0, 32'hFFFF_0002, "status_cnt_held");

      // Restart at 3/10
      bus(1'b1, A_PERIOD, 32'd10, 0, 0, "wr_period10");
      bus(1'b1, A_DUTY,   32'd3,  0, 0, "wr_duty3");
      bus(1'b1, A_CTRL,   32'h0,  0, 0, "wr_ctrl_off");
      bus(1'b1, A_CTRL,   32'h9,  0, 0, "wr_ctrl_on");

      // Direction change with 16-cycle deadtime
      wait_irq("d_sync");
      base = cyc_n;
      bus(1'b1, A_CTRL, 32'hB, 0, 0, "wr_dir1");
      cyc_chk("d_forced_low", 0, mk(0, 0, 0, 0));
      bus(1'b0, A_STATUS, 0, 32'h2, 32'h2, "dead_start");
      for (int j = 5; j <= 16; j++)
         cyc_chk("d_dead", 1, mk(0, j == 10, 0, 0));
      bus(1'b0, A_STATUS, 0, 32'h2, 32'h2, "dead_last");
      cyc_chk("d_dir_flip", 0, mk(0, 0, 1, 0));
      bus(1'b0, A_STATUS, 0, 32'h0, 32'h2, "dead_over");
      for (int j = 21; j <= 35; j++)
         cyc_chk("d_resume", 1, mk(((j - 1) % 10) < 3, (j % 10) == 0, 1, 0));

      // Brake mid high phase
      wait_irq("e_sync");
      base = cyc_n;
      bus(1'b1, A_CTRL, 32'hF, 0, 0, "wr_brake");
      cyc_chk("e_brake_on", 0, mk(0, 0, 1, 1));
      for (int j = 3; j <= 20; j++)
         cyc_chk("e_braked", 1, mk(0, (j % 10) == 0, 1, 1));
      bus(1'b1, A_CTRL, 32'hB, 0, 0, "wr_unbrake");
      cyc_chk("e_brake_off", 0, mk(1, 0, 1, 0));
      for (int j = 23; j <= 32; j++)
         cyc_chk("e_in_phase", 1, mk(((j - 1) % 10) < 3, (j % 10) == 0, 1, 0));

      // Reset during DEAD
      bus(1'b1, A_CTRL, 32'h9, 0, 0, "wr_dir0");
      cyc_chk("f_in_dead", 2, mk(0, 0, 1, 0));
      rst = 1'b1;
      cyc_chk("f_reset_out", 1, 5'b0);
      rst = 1'b0;
      bus(1'b0, A_CTRL,   0, 32'h0, 32'hFFFF_FFFF, "f_ctrl");
      bus(1'b0, A_PERIOD, 0, 32'h0, 32'hFFFF_FFFF, "f_period");
      bus(1'b0, A_DUTY,   0, 32'h0, 32'hFFFF_FFFF, "f_duty");
      bus(1'b0, A_STATUS, 0, 32'h0, 32'hFFFF_FFFF, "f_status");

      // IDLE: dir follows CTRL.dir, pwm stays low
      bus(1'b1, A_CTRL, 32'h2, 0, 0, "wr_idle_dir");
      cyc_chk("g_idle_dir", 0, mk(0, 0, 1, 0));
      bus(1'b0, A_CTRL, 0, 32'h2, 32'hFFFF_FFFF, "g_ctrl_rb");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_motor_pwm.md
Name: wb_motor_pwm

Overview:
Wishbone-compliant wheel-motor PWM driver. It is the actuator-side counterpart of the wheel encoder monitor: software writes the period, duty, direction and brake, and the block drives the H-bridge. The block sits on the same PLB-to-Wishbone bridge as the encoder. It raises a per-period interrupt so software can close the speed loop.

Parameters:
C_WB_DWIDTH, 32, Wishbone data/address width
C_WB_CTRLREG, 0, byte address of CTRL (R/W)
C_WB_PERIODREG, 4, byte address of PERIOD (R/W)
C_WB_DUTYREG, 8, byte address of DUTY (R/W)
C_WB_STATUSREG, 12, byte address of STATUS (R, write-1-to-clear)
C_DEADTIME, 16, cycles pwm_o is forced low on a direction change (>=1)

Ports:
wb_clk_i  in  1  system clock, all logic on rising edge
wb_rst_i  in  1  synchronous active-high reset
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle valid
wb_stb_i  in  1  strobe
wb_ack_o  out  1  transfer acknowledge
wb_data_i  in  C_WB_DWIDTH  write data
wb_data_o  out  C_WB_DWIDTH  read data
wb_addr_i  in  C_WB_DWIDTH  byte address, compared in full
pwm_o  out  1  PWM to H-bridge enable
dir_o  out  1  motor direction
brake_o  out  1  brake request
irq_o  out  1  one-cycle period-done interrupt

Behaviour:
- Reset (wb_clk_i edge with wb_rst_i=1): every register, counter, output and wb_data_o goes to 0; the FSM goes to IDLE.
- Bit numbering below is by value: bit 0 is the LSB.
- Bus handshake:
  - wb_ack_o <= stb & cyc & ~wb_ack_o, so every access is acked with a single-cycle pulse one cycle after the strobe.
  - A master holding stb across two accesses sees ack every other cycle.
  - Writes take effect on the ack cycle edge.
  - Reads register wb_data_o on the same edge; unmapped addresses read 0, and writes to them are acked and ignored.
- CTRL register: bit0 enable, bit1 dir, bit2 brake, bit3 irq_en. Other bits read 0.
- PERIOD and DUTY: bits[15:0] are the value; upper bits read 0.
- STATUS read: bit0 period_done (sticky); bit1 dead (FSM in DEAD); bits[31:16] the current counter value.
- STATUS write: writing 1 to bit0 clears period_done. If a set and a clear land in the same cycle, set wins.
- Shadowing:
  - cnt is 16-bit. period_s and duty_s are shadow copies of PERIOD and DUTY.
  - Shadows load on IDLE->RUN and on every wrap (cnt == period_s-1), so there are no mid-period glitches.
- FSM IDLE:
  - cnt=0, pwm_o=0, dir_o follows CTRL.dir directly.
  - enable=1 -> RUN (shadows load).
- FSM RUN:
  - cnt increments and wraps to 0 at period_s-1.
  - pwm_o is registered: pwm_o <= (cnt < duty_s), so it lags cnt by one cycle.
  - duty_s >= period_s gives 100% high; duty_s=0 gives always low.
  - period_s=0: cnt held at 0, pwm_o=0, no wraps, no irq.
  - At a wrap: period_done<=1, and irq_o<=1 for one cycle if irq_en.
  - enable=0 -> IDLE next cycle; cnt is cleared and pwm_o goes low on that edge.
  - CTRL.dir != dir_o -> DEAD: pwm_o forced 0, deadtime counter loads C_DEADTIME-1.
- FSM DEAD:
  - pwm_o=0; the deadtime counter decrements while cnt keeps running (wraps and irqs continue).
  - At deadtime counter 0: dir_o <= CTRL.dir, then return to RUN.
  - enable=0 in DEAD -> IDLE immediately.
  - A dir toggle back to the old value during DEAD still completes the deadtime, with no dir_o change.
- brake_o = CTRL.brake, registered. Brake also forces pwm_o=0 in any state without altering FSM state or the counters.
- Reset mid-operation is synchronous: pwm_o=0 on the first reset edge, and all state returns to IDLE.

Decomposition:
- Shared package: register address offsets, CTRL/STATUS bit indices, FSM state encodings (IDLE=2'd0, RUN=2'd1, DEAD=2'd2), the 16-bit counter width constant.
- One sub-module, pwm_core: counter, shadows, FSM, deadtime and pwm/dir/irq generation.
- The top level keeps the Wishbone decode, register file and STATUS logic.

Test Plan:
- Reset then read all four registers -> each returns 0; ack pulses exactly one cycle after each strobe; all outputs 0.
- PERIOD=10, DUTY=3, CTRL=0x9 -> pwm_o high 3 cycles, low 7 cycles, repeating; irq_o one-cycle pulse every 10 cycles; STATUS bit0 set, cleared by writing 0x1.
- While running, write DUTY=8 mid-period -> the current period keeps 3-high; the next period is 8-high. DUTY=12 -> constant high. PERIOD=0 -> pwm_o=0 and no irq.
- Toggle CTRL.dir while running, C_DEADTIME=16 -> pwm_o low on the next edge; STATUS bit1=1 for 16 cycles; dir_o flips after 16 cycles; then PWM resumes; irqs continue throughout.
- Set CTRL.brake mid-high-phase -> pwm_o=0 next cycle, brake_o=1, cnt continues; clear brake -> PWM resumes in phase.
- Assert wb_rst_i during DEAD with pwm active -> next cycle all outputs 0 and all registers read 0.
